// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and its request/response front end.
package alu_pkg;
  localparam int ALU_BW = 16;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  typedef logic [3:0] alu_opcode_t;
  typedef logic [2:0] alu_flags_t;

  typedef struct packed {
    logic [ALU_BW-1:0] result;
    alu_flags_t        flags;
  } alu_rsp_t;
endpackage

// File: rtl/alu_rsp_fifo.sv
// In-order response FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == (AW+1)'(0));
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/alu_seq_chk.sv
// Protocol checker for the sequencer: the issue stage must never push into a full FIFO.
module alu_seq_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
endmodule

// File: rtl/alu_sequencer.sv
// ALU front end: registers accepted requests onto the ALU inputs, then queues result+flags.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int BW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_opcode,
  input  logic [BW-1:0] req_a,
  input  logic [BW-1:0] req_b,
  output logic [BW-1:0] alu_in_a,
  output logic [BW-1:0] alu_in_b,
  output logic [3:0]    alu_opcode,
  input  logic [BW-1:0] alu_out,
  input  logic [2:0]    alu_flags,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [BW-1:0] rsp_result,
  output logic [2:0]    rsp_flags,
  output logic [2:0]    sticky_flags,
  input  logic          clr_sticky,
  output logic [CW-1:0] op_count,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = BW + 3;

  logic          s1_valid_r;
  logic          req_fire_s;
  logic          pop_s;
  logic [AW:0]   fifo_count_s;
  logic [AW+1:0] occupancy_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic [FW-1:0] fifo_dout_s;
  alu_flags_t    sticky_r;
  logic [CW-1:0] op_count_r;

  // Counting the op in flight in stage 1 reserves its FIFO slot before it lands.
  assign occupancy_s  = {1'b0, fifo_count_s} + {{(AW+1){1'b0}}, s1_valid_r};
  assign req_ready    = (occupancy_s < (AW+2)'(DEPTH));
  assign req_fire_s   = req_valid && req_ready;
  assign pop_s        = rsp_ready && !fifo_empty_s;
  assign rsp_valid    = !fifo_empty_s;
  assign busy         = s1_valid_r || !fifo_empty_s;
  assign sticky_flags = sticky_r;
  assign op_count     = op_count_r;

  // Issue stage: ALU inputs only change on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      alu_in_a   <= '0;
      alu_in_b   <= '0;
      alu_opcode <= 4'h0;
    end else begin
      s1_valid_r <= req_fire_s;
      if (req_fire_s) begin
        alu_in_a   <= req_a;
        alu_in_b   <= req_b;
        alu_opcode <= req_opcode;
      end
    end
  end

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid_r),
    .pop   (pop_s),
    .din   ({alu_out, alu_flags}),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  alu_seq_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid_r),
    .full  (fifo_full_s)
  );

  // Response head, forced to zero when nothing is queued.
  always_comb begin
    rsp_result = '0;
    rsp_flags  = 3'b000;
    if (rsp_valid) begin
      rsp_result = fifo_dout_s[FW-1:3];
      rsp_flags  = fifo_dout_s[2:0];
    end else begin
      rsp_result = '0;
      rsp_flags  = 3'b000;
    end
  end

  // Sticky flags: a clear coinciding with a capture keeps only the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 3'b000;
    end else if (s1_valid_r) begin
      sticky_r <= (clr_sticky ? 3'b000 : sticky_r) | alu_flags;
    end else if (clr_sticky) begin
      sticky_r <= 3'b000;
    end
  end

  // Completed-response counter, wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= '0;
    end else if (pop_s) begin
      op_count_r <= op_count_r + CW'(1);
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: a behavioural ALU feeds the DUT; a negedge monitor checks every response.
module tb_alu_sequencer;
  localparam int BW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_opcode = 4'h0;
  logic [BW-1:0] req_a = '0;
  logic [BW-1:0] req_b = '0;
  logic [BW-1:0] alu_in_a, alu_in_b;
  logic [3:0]    alu_opcode;
  logic [BW-1:0] alu_out;
  logic [2:0]    alu_flags;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [BW-1:0] rsp_result;
  logic [2:0]    rsp_flags;
  logic [2:0]    sticky_flags;
  logic          clr_sticky = 1'b0;
  logic [CW-1:0] op_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.BW(BW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .sticky_flags(sticky_flags),
    .clr_sticky(clr_sticky), .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {result, overflow, negative, zero}.
  function automatic logic [18:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'h0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a;
      4'h6: r = a << b[3:0];
      default: r = b;
    endcase
    return {r, v, r[15], (r == 16'h0000)};
  endfunction

  assign {alu_out, alu_flags} = alu_ref(alu_opcode, alu_in_a, alu_in_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state, owned by the monitor.
  logic [18:0] exp_q[$];
  int unsigned resp_cnt = 0;
  bit          hs_last = 1'b0;
  logic [15:0] last_a = '0, last_b = '0;
  logic [3:0]  last_op = 4'h0;
  int          mon_in_fifo;
  logic [18:0] mon_e;

  // Monitor: outstanding ops = accepted minus consumed; the newest one is still in the ALU stage.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      resp_cnt = 0;
      hs_last  = 1'b0;
      last_a   = '0;
      last_b   = '0;
      last_op  = 4'h0;
    end else begin
      mon_in_fifo = exp_q.size() - (hs_last ? 1 : 0);
      chk("rsp_valid", rsp_valid, mon_in_fifo > 0);
      chk("busy", busy, exp_q.size() > 0);
      chk("req_ready", req_ready, exp_q.size() < DEPTH);
      chk("op_count", op_count, resp_cnt % (1 << CW));
      chk("alu_in", {alu_opcode, alu_in_a, alu_in_b}, {last_op, last_a, last_b});
      if (!rsp_valid) chk("rsp_idle_zero", {rsp_result, rsp_flags}, 32'h0);
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", {rsp_result, rsp_flags}, mon_e);
        end
        resp_cnt++;
      end
      hs_last = req_valid && req_ready;
      if (hs_last) begin
        exp_q.push_back(alu_ref(req_opcode, req_a, req_b));
        last_a  = req_a;
        last_b  = req_b;
        last_op = req_opcode;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin n++; @(negedge clk); end
    chk("issue_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", {rsp_result, rsp_flags}, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_op_count", op_count, 0);
    chk("rst_sticky", sticky_flags, 3'b000);
    chk("rst_alu_in", {alu_opcode, alu_in_a, alu_in_b}, 36'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [18:0] e;
    logic [2:0]  or_acc;
    bit          acc;

    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single op: 3 + 4.
    issue(4'h0, 16'h0003, 16'h0004);
    chk("t2_alu_a", alu_in_a, 16'h0003);
    chk("t2_alu_b", alu_in_b, 16'h0004);
    chk("t2_not_yet", rsp_valid, 1'b0);
    cycles(1);
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_result", rsp_result, 16'h0007);
    chk("t2_flags", rsp_flags, 3'b000);
    rsp_ready = 1'b1;
    cycles(1);
    rsp_ready = 1'b0;
    chk("t2_op_count", op_count, 1);

    // Back-pressure: four fit, fifth stalls, then everything drains in order.
    for (int k = 1; k <= 4; k++) issue(4'h5, 16'(k), 16'h0000);
    req_valid = 1'b1; req_opcode = 4'h5; req_a = 16'h0005; req_b = 16'h0000;
    cycles(3);
    chk("t3_stalled", req_ready, 1'b0);
    rsp_ready = 1'b1;
    issue(4'h5, 16'h0005, 16'h0000);
    issue(4'h5, 16'h0006, 16'h0000);
    drain();

    // Full FIFO with simultaneous push/pop every cycle.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) issue(4'h1, 16'($urandom), 16'($urandom));
    cycles(1);
    chk("t4_full", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) issue(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    drain();

    // Sticky flags accumulate; clear coinciding with a capture keeps only new flags.
    clr_sticky = 1'b1; cycles(1); clr_sticky = 1'b0;
    chk("t5_cleared", sticky_flags, 3'b000);
    issue(4'h0, 16'h0000, 16'h0000);
    issue(4'h0, 16'h8000, 16'h8001);
    cycles(3);
    chk("t5_or", sticky_flags, 3'b101);
    issue(4'h5, 16'h8000, 16'h0000);
    clr_sticky = 1'b1; cycles(1); clr_sticky = 1'b0;
    chk("t5_clr_push", sticky_flags, 3'b010);
    clr_sticky = 1'b1; cycles(1); clr_sticky = 1'b0;
    chk("t5_clr_only", sticky_flags, 3'b000);
    drain();

    // Random traffic with random back-pressure; op_count wraps several times.
    or_acc = 3'b000;
    for (int i = 0; i < 150; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid && $urandom_range(0, 4) != 0) begin
        req_valid  = 1'b1;
        req_opcode = 4'($urandom_range(0, 7));
        req_a      = 16'($urandom);
        req_b      = 16'($urandom);
      end
      @(negedge clk);
      acc = req_valid && req_ready;
      if (acc) begin
        e = alu_ref(req_opcode, req_a, req_b);
        or_acc = or_acc | e[2:0];
      end
      @(posedge clk); #1;
      if (acc) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    drain();
    cycles(1);
    chk("rand_sticky", sticky_flags, or_acc);

    // Reset with three queued results and one in the ALU stage.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) issue(4'h4, 16'($urandom), 16'($urandom));
    chk("t1_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    cycles(5);
    chk("t1_after_busy", busy, 1'b0);
    chk("t1_after_valid", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Front end that drives the combinational ALU. Accepts operation requests (opcode, two operands) on a valid/ready channel and presents them to the ALU one cycle later. Captures the ALU result and flags into an in-order response FIFO, returned on a valid/ready response channel. Also keeps sticky flags and a completed-operation counter for the control/status logic.

Parameters:
BW, 16, operand/result bitwidth (matches ALU BW)
DEPTH, 4, response FIFO depth (power of two, >=2)
CW, 8, width of op_count

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_opcode  in  4  ALU opcode
req_a  in  BW  operand A
req_b  in  BW  operand B
alu_in_a  out  BW  to ALU in_a
alu_in_b  out  BW  to ALU in_b
alu_opcode  out  4  to ALU opcode
alu_out  in  BW  from ALU out
alu_flags  in  3  from ALU flags {overflow, negative, zero}
rsp_valid  out  1  response FIFO non-empty
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_result  out  BW  head-of-FIFO result
rsp_flags  out  3  head-of-FIFO flags
sticky_flags  out  3  OR of flags of all results since reset/clear
clr_sticky  in  1  synchronous clear of sticky_flags
op_count  out  CW  number of completed responses, wraps
busy  out  1  s1_valid or FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, FIFO empty, alu_in_a/alu_in_b/alu_opcode=0, sticky_flags=0, op_count=0. Outputs: rsp_valid=0, rsp_result=0, rsp_flags=0, busy=0, req_ready=1. Reset mid-operation drops all in-flight and queued ops without producing responses.
- Stage 1 (issue): on request handshake at edge N, register opcode/a/b into the ALU-driving registers and set s1_valid. ALU inputs are stable throughout cycle N+1.
- When no handshake occurs, the ALU-driving registers hold their last value (no toggling); s1_valid clears.
- Stage 2 (capture): at edge N+1, if s1_valid, push {alu_out, alu_flags} into the FIFO. rsp_valid is visible in cycle N+1 after the edge. Request-to-response latency is 2 edges; throughput is 1 op/cycle.
- req_ready = (fifo_count + s1_valid) < DEPTH. It is computed from registered state only: no combinational path from rsp_ready or req_valid to req_ready.
- FIFO: in-order, pointer wrap modulo DEPTH, count 0..DEPTH. Simultaneous push and pop is legal at any count, including full and empty-with-push.
  - Push when full cannot occur because req_ready guarantees space. Assertion: never push when count==DEPTH.
  - Pop when empty is ignored.
- rsp_result/rsp_flags show the FIFO head when rsp_valid, else 0.
- sticky_flags: on push, sticky <= sticky | alu_flags. On clr_sticky without push, sticky <= 0. If clr_sticky and push occur in the same cycle, sticky <= alu_flags (clear first, then new flags).
- op_count increments on each response handshake and wraps 2^CW-1 -> 0.
- Width rules: results and flags are passed through unmodified. The sequencer does no arithmetic on data.

Decomposition:
- Package alu_pkg holds:
  - ALU_BW=16 and flag index constants FLAG_Z=0, FLAG_N=1, FLAG_V=2;
  - typedef alu_opcode_t (logic[3:0]);
  - typedef alu_flags_t (logic[2:0]);
  - packed struct alu_rsp_t {result, flags}.
- One sub-module alu_rsp_fifo (parameters DEPTH and width; ports push, pop, din, dout, count, empty, full) holds the storage. alu_sequencer holds stage 1, the sticky flags, the counter and the ALU instance wiring.

Test Plan:
1. Assert rst_n=0 while 3 results are queued and s1_valid=1 -> all outputs 0 immediately (async). After release, req_ready=1, busy=0, and no stale responses appear.
2. Single request, opcode=4'h0, a=16'h0003, b=16'h0004; bench ALU returns 16'h0007, flags 3'b000 -> alu_in_a=3 and alu_in_b=4 in cycle 1. rsp_valid in cycle 2 with rsp_result=16'h0007. op_count=1 after the handshake.
3. DEPTH=4, rsp_ready=0, req_valid held with a=1..6 -> exactly 4 accepted, then req_ready=0. Then rsp_ready=1 -> results drain in order 1..4. req_ready re-asserts the cycle after the first pop, and a=5,6 follow in order.
4. Full FIFO with rsp_ready=1 and req_valid=1 every cycle -> one push and one pop per cycle, count stays constant, no loss or duplication over 20 ops.
5. Flags 3'b001 then 3'b100 pushed -> sticky_flags=3'b101. Then clr_sticky asserted in the same cycle as a push with flags 3'b010 -> sticky_flags=3'b010.
6. CW=4, 17 completed responses -> op_count reads 0 after the 16th and 1 after the 17th.
